// File: rtl/pipe_control_if.sv
// ---------------------------------------------------------------------------
// pipe_control_if
// Purpose : bundles every non-clock/reset signal between the ID-stage decoder,
//           the datapath pipeline registers and the pipe_control hazard block.
// Ports (slave = pipe_control view):
//   inputs  : id_valid, id_ctrl, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
//             id_src_fp, id_dest, id_dest_fp, id_reg_we, id_is_load,
//             id_fpu_multi, ex_branch_taken
//   outputs : stall_if, flush_ifid, fpu_busy, ex/mem/wb_valid,
//             ex/mem/wb_ctrl, fwd_a, fwd_b
// The master modport is the decoder/datapath side (or a testbench).
// ---------------------------------------------------------------------------
interface pipe_control_if #(
    parameter int CTRL_W = 24,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [CTRL_W-1:0] id_ctrl;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic              id_src_fp;
    logic [REG_AW-1:0] id_dest;
    logic              id_dest_fp;
    logic              id_reg_we;
    logic              id_is_load;
    logic              id_fpu_multi;
    logic              ex_branch_taken;

    logic              stall_if;
    logic              flush_ifid;
    logic              fpu_busy;
    logic              ex_valid;
    logic              mem_valid;
    logic              wb_valid;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CTRL_W-1:0] mem_ctrl;
    logic [CTRL_W-1:0] wb_ctrl;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;

    modport master (
        output id_valid, id_ctrl, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_src_fp, id_dest, id_dest_fp, id_reg_we, id_is_load,
               id_fpu_multi, ex_branch_taken,
        input  stall_if, flush_ifid, fpu_busy, ex_valid, mem_valid, wb_valid,
               ex_ctrl, mem_ctrl, wb_ctrl, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_ctrl, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_src_fp, id_dest, id_dest_fp, id_reg_we, id_is_load,
               id_fpu_multi, ex_branch_taken,
        output stall_if, flush_ifid, fpu_busy, ex_valid, mem_valid, wb_valid,
               ex_ctrl, mem_ctrl, wb_ctrl, fwd_a, fwd_b
    );
endinterface

// File: rtl/pipe_control.sv
// ---------------------------------------------------------------------------
// pipe_control
// Purpose : pipelined DLX control. Carries the decoded control bundle of the
//           ID instruction through ID/EX, EX/MEM and MEM/WB with valid bits,
//           detects load-use and multi-cycle FPU hazards, applies branch
//           flushes and produces EX operand forwarding selects.
// Ports   :
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - pipe_control_if.slave (ID fields, branch resolution in,
//            stall/flush/busy, stage valids/ctrls, fwd_a/fwd_b out)
// Forward select encoding: 00 regfile, 01 EX/MEM, 10 MEM/WB.
// ---------------------------------------------------------------------------
module pipe_control #(
    parameter int CTRL_W  = 24,
    parameter int REG_AW  = 5,
    parameter int FPU_LAT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    pipe_control_if.slave  bus
);

    localparam logic [3:0] FPU_INIT = 4'(FPU_LAT - 1);

    // EX stage registers (sources are kept for forwarding)
    logic              r_ex_valid;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [REG_AW-1:0] r_ex_rs1;
    logic [REG_AW-1:0] r_ex_rs2;
    logic              r_ex_uses_rs1;
    logic              r_ex_uses_rs2;
    logic              r_ex_src_fp;
    logic [REG_AW-1:0] r_ex_dest;
    logic              r_ex_dest_fp;
    logic              r_ex_we;
    logic              r_ex_load;
    logic [3:0]        r_fpu_cnt;

    // MEM stage registers
    logic              r_mem_valid;
    logic [CTRL_W-1:0] r_mem_ctrl;
    logic [REG_AW-1:0] r_mem_dest;
    logic              r_mem_dest_fp;
    logic              r_mem_we;
    logic              r_mem_load;

    // WB stage registers
    logic              r_wb_valid;
    logic [CTRL_W-1:0] r_wb_ctrl;
    logic [REG_AW-1:0] r_wb_dest;
    logic              r_wb_dest_fp;
    logic              r_wb_we;

    logic              w_fpu_busy;
    logic              w_flush;
    logic              w_load_use;
    logic              w_stall;
    logic              w_ex_bubble;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;

    // A producer matches a source only inside the same register file;
    // GPR r0 is hardwired to zero so it never creates a dependency, FPR f0 does.
    function automatic logic reg_match(
        input logic              stg_valid,
        input logic              stg_we,
        input logic [REG_AW-1:0] stg_dest,
        input logic              stg_dest_fp,
        input logic [REG_AW-1:0] src,
        input logic              src_fp
    );
        return stg_valid && stg_we && (stg_dest == src) &&
               (stg_dest_fp == src_fp) && (src_fp || (src != '0));
    endfunction

    assign w_fpu_busy = (r_fpu_cnt != 4'd0);

    // A branch cannot legally resolve while the FPU owns EX, so it is ignored then.
    // Gating with rst_n keeps flush low during reset.
    assign w_flush = bus.ex_branch_taken && !w_fpu_busy && rst_n;

    assign w_load_use = bus.id_valid && r_ex_valid && r_ex_load &&
                        ((bus.id_uses_rs1 &&
                          reg_match(r_ex_valid, r_ex_we, r_ex_dest, r_ex_dest_fp,
                                    bus.id_rs1, bus.id_src_fp)) ||
                         (bus.id_uses_rs2 &&
                          reg_match(r_ex_valid, r_ex_we, r_ex_dest, r_ex_dest_fp,
                                    bus.id_rs2, bus.id_src_fp)));

    // Flush squashes the ID instruction, so its load-use hazard is moot.
    assign w_stall     = w_fpu_busy || (w_load_use && !w_flush);
    assign w_ex_bubble = w_flush || w_load_use || !bus.id_valid;

    // EX register: holds while the FPU is busy, otherwise takes ID or a bubble.
    // The counter is armed with FPU_LAT-1 so a multi-cycle op sits in EX
    // for exactly FPU_LAT cycles (FPU_LAT-1 busy cycles plus the final one).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_ctrl     <= '0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_uses_rs1 <= 1'b0;
            r_ex_uses_rs2 <= 1'b0;
            r_ex_src_fp   <= 1'b0;
            r_ex_dest     <= '0;
            r_ex_dest_fp  <= 1'b0;
            r_ex_we       <= 1'b0;
            r_ex_load     <= 1'b0;
            r_fpu_cnt     <= 4'd0;
        end else if (w_fpu_busy) begin
            r_fpu_cnt <= r_fpu_cnt - 4'd1;
        end else if (w_ex_bubble) begin
            r_ex_valid    <= 1'b0;
            r_ex_ctrl     <= '0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_uses_rs1 <= 1'b0;
            r_ex_uses_rs2 <= 1'b0;
            r_ex_src_fp   <= 1'b0;
            r_ex_dest     <= '0;
            r_ex_dest_fp  <= 1'b0;
            r_ex_we       <= 1'b0;
            r_ex_load     <= 1'b0;
            r_fpu_cnt     <= 4'd0;
        end else begin
            r_ex_valid    <= 1'b1;
            r_ex_ctrl     <= bus.id_ctrl;
            r_ex_rs1      <= bus.id_rs1;
            r_ex_rs2      <= bus.id_rs2;
            r_ex_uses_rs1 <= bus.id_uses_rs1;
            r_ex_uses_rs2 <= bus.id_uses_rs2;
            r_ex_src_fp   <= bus.id_src_fp;
            r_ex_dest     <= bus.id_dest;
            r_ex_dest_fp  <= bus.id_dest_fp;
            r_ex_we       <= bus.id_reg_we;
            r_ex_load     <= bus.id_is_load;
            r_fpu_cnt     <= bus.id_fpu_multi ? FPU_INIT : 4'd0;
        end
    end

    // MEM register: follows EX, but takes bubbles while the FPU holds EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid   <= 1'b0;
            r_mem_ctrl    <= '0;
            r_mem_dest    <= '0;
            r_mem_dest_fp <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_load    <= 1'b0;
        end else if (w_fpu_busy) begin
            r_mem_valid   <= 1'b0;
            r_mem_ctrl    <= '0;
            r_mem_dest    <= '0;
            r_mem_dest_fp <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_load    <= 1'b0;
        end else begin
            r_mem_valid   <= r_ex_valid;
            r_mem_ctrl    <= r_ex_ctrl;
            r_mem_dest    <= r_ex_dest;
            r_mem_dest_fp <= r_ex_dest_fp;
            r_mem_we      <= r_ex_we;
            r_mem_load    <= r_ex_load;
        end
    end

    // WB register: unconditionally follows MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid   <= 1'b0;
            r_wb_ctrl    <= '0;
            r_wb_dest    <= '0;
            r_wb_dest_fp <= 1'b0;
            r_wb_we      <= 1'b0;
        end else begin
            r_wb_valid   <= r_mem_valid;
            r_wb_ctrl    <= r_mem_ctrl;
            r_wb_dest    <= r_mem_dest;
            r_wb_dest_fp <= r_mem_dest_fp;
            r_wb_we      <= r_mem_we;
        end
    end

    // Forwarding: the youngest producer (MEM) wins. A load in MEM has no data
    // yet, so its EX/MEM path is suppressed and WB is considered instead.
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (r_ex_uses_rs1) begin
            if (!r_mem_load && reg_match(r_mem_valid, r_mem_we, r_mem_dest,
                                         r_mem_dest_fp, r_ex_rs1, r_ex_src_fp))
                w_fwd_a = 2'b01;
            else if (reg_match(r_wb_valid, r_wb_we, r_wb_dest, r_wb_dest_fp,
                               r_ex_rs1, r_ex_src_fp))
                w_fwd_a = 2'b10;
        end
        if (r_ex_uses_rs2) begin
            if (!r_mem_load && reg_match(r_mem_valid, r_mem_we, r_mem_dest,
                                         r_mem_dest_fp, r_ex_rs2, r_ex_src_fp))
                w_fwd_b = 2'b01;
            else if (reg_match(r_wb_valid, r_wb_we, r_wb_dest, r_wb_dest_fp,
                               r_ex_rs2, r_ex_src_fp))
                w_fwd_b = 2'b10;
        end
    end

    assign bus.stall_if   = w_stall;
    assign bus.flush_ifid = w_flush;
    assign bus.fpu_busy   = w_fpu_busy;
    assign bus.ex_valid   = r_ex_valid;
    assign bus.mem_valid  = r_mem_valid;
    assign bus.wb_valid   = r_wb_valid;
    assign bus.ex_ctrl    = r_ex_ctrl;
    assign bus.mem_ctrl   = r_mem_ctrl;
    assign bus.wb_ctrl    = r_wb_ctrl;
    assign bus.fwd_a      = w_fwd_a;
    assign bus.fwd_b      = w_fwd_b;

endmodule

// File: tb/tb_pipe_control.sv
// ---------------------------------------------------------------------------
// tb_pipe_control
// Purpose : self-checking bench for pipe_control. Directed scenarios cover
//           load-use, forwarding priority, multi-cycle FPU, branch flush,
//           FP/GPR namespaces and reset mid-op; a random phase follows.
//           Expectations come from an instruction-level model that tracks
//           which instruction sits in EX/MEM/WB and how long EX has held it.
// Ports   : none (instantiates pipe_control_if and pipe_control).
// ---------------------------------------------------------------------------
module tb_pipe_control;

    localparam int CTRL_W  = 24;
    localparam int REG_AW  = 5;
    localparam int FPU_LAT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipe_control_if #(.CTRL_W(CTRL_W), .REG_AW(REG_AW)) bus ();

    pipe_control #(.CTRL_W(CTRL_W), .REG_AW(REG_AW), .FPU_LAT(FPU_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic              v;
        logic [CTRL_W-1:0] ctrl;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              u1;
        logic              u2;
        logic              sfp;
        logic [REG_AW-1:0] dest;
        logic              dfp;
        logic              we;
        logic              ld;
        logic              fm;
    } instr_t;

    // Model: the instruction occupying each stage plus cycles spent in EX.
    instr_t mEx, mMem, mWb;
    int     mExAge;

    int     checks = 0;
    int     errors = 0;
    logic   lastStall;
    logic   lastFlush;
    logic   expStall;

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t bubble();
        instr_t b;
        b = '{default: '0};
        return b;
    endfunction

    function automatic instr_t mk(input logic [CTRL_W-1:0] ctrl,
                                  input logic [REG_AW-1:0] rs1, input logic u1,
                                  input logic [REG_AW-1:0] rs2, input logic u2,
                                  input logic sfp,
                                  input logic [REG_AW-1:0] dest, input logic dfp,
                                  input logic we, input logic ld, input logic fm);
        instr_t r;
        r.v = 1'b1;  r.ctrl = ctrl; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2;
        r.u2 = u2;   r.sfp = sfp;   r.dest = dest; r.dfp = dfp; r.we = we;
        r.ld = ld;   r.fm = fm;
        return r;
    endfunction

    function automatic instr_t randInstr();
        instr_t r;
        int kind;
        kind   = $urandom_range(0, 9);
        r.v    = ($urandom_range(0, 9) != 0);
        r.ctrl = CTRL_W'($urandom);
        r.rs1  = REG_AW'($urandom_range(0, 3));
        r.rs2  = REG_AW'($urandom_range(0, 3));
        r.u1   = 1'($urandom_range(0, 1));
        r.u2   = 1'($urandom_range(0, 1));
        r.sfp  = 1'($urandom_range(0, 1));
        r.dest = REG_AW'($urandom_range(0, 3));
        r.dfp  = 1'($urandom_range(0, 1));
        r.we   = ($urandom_range(0, 7) != 0);
        r.ld   = (kind < 3);
        r.fm   = (kind == 3);
        if (r.fm) begin
            r.sfp = 1'b1;
            r.dfp = 1'b1;
        end
        return r;
    endfunction

    // Does stage instruction s write register (idx, fp)?
    function automatic logic writes(input instr_t s, input logic [REG_AW-1:0] idx,
                                    input logic fp);
        return s.v && s.we && (s.dest == idx) && (s.dfp == fp) &&
               (fp || (idx != 0));
    endfunction

    function automatic logic modelBusy();
        return mEx.v && mEx.fm && (mExAge < FPU_LAT);
    endfunction

    function automatic logic modelLoadUse(input instr_t id);
        return id.v && mEx.v && mEx.ld &&
               ((id.u1 && writes(mEx, id.rs1, id.sfp)) ||
                (id.u2 && writes(mEx, id.rs2, id.sfp)));
    endfunction

    function automatic logic [1:0] modelFwd(input logic [REG_AW-1:0] src,
                                            input logic fp, input logic used);
        if (!mEx.v || !used) return 2'd0;
        if (writes(mMem, src, fp) && !mMem.ld) return 2'd1;
        if (writes(mWb, src, fp)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic modelReset();
        mEx    = bubble();
        mMem   = bubble();
        mWb    = bubble();
        mExAge = 0;
    endtask

    task automatic checkRegs();
        checkOutput("ex_valid",  32'(bus.ex_valid),  32'(mEx.v));
        checkOutput("mem_valid", 32'(bus.mem_valid), 32'(mMem.v));
        checkOutput("wb_valid",  32'(bus.wb_valid),  32'(mWb.v));
        checkOutput("ex_ctrl",   32'(bus.ex_ctrl),   32'(mEx.ctrl));
        checkOutput("mem_ctrl",  32'(bus.mem_ctrl),  32'(mMem.ctrl));
        checkOutput("wb_ctrl",   32'(bus.wb_ctrl),   32'(mWb.ctrl));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_exv"},   32'(bus.ex_valid),   0);
        checkOutput({tag, "_memv"},  32'(bus.mem_valid),  0);
        checkOutput({tag, "_wbv"},   32'(bus.wb_valid),   0);
        checkOutput({tag, "_exc"},   32'(bus.ex_ctrl),    0);
        checkOutput({tag, "_memc"},  32'(bus.mem_ctrl),   0);
        checkOutput({tag, "_wbc"},   32'(bus.wb_ctrl),    0);
        checkOutput({tag, "_stall"}, 32'(bus.stall_if),   0);
        checkOutput({tag, "_flush"}, 32'(bus.flush_ifid), 0);
        checkOutput({tag, "_busy"},  32'(bus.fpu_busy),   0);
        checkOutput({tag, "_fwda"},  32'(bus.fwd_a),      0);
        checkOutput({tag, "_fwdb"},  32'(bus.fwd_b),      0);
    endtask

    // One cycle: drive ID just after negedge, check combinational outputs,
    // advance the model on posedge, check registered outputs at next negedge.
    task automatic applyStimulus(input instr_t id, input logic br);
        logic busy, lu, fl;
        bus.id_valid        = id.v;
        bus.id_ctrl         = id.ctrl;
        bus.id_rs1          = id.rs1;
        bus.id_rs2          = id.rs2;
        bus.id_uses_rs1     = id.u1;
        bus.id_uses_rs2     = id.u2;
        bus.id_src_fp       = id.sfp;
        bus.id_dest         = id.dest;
        bus.id_dest_fp      = id.dfp;
        bus.id_reg_we       = id.we;
        bus.id_is_load      = id.ld;
        bus.id_fpu_multi    = id.fm;
        bus.ex_branch_taken = br;
        #1;
        busy     = modelBusy();
        lu       = modelLoadUse(id);
        fl       = br && !busy;
        expStall = busy || (lu && !fl);
        checkOutput("fpu_busy",   32'(bus.fpu_busy),   32'(busy));
        checkOutput("flush_ifid", 32'(bus.flush_ifid), 32'(fl));
        checkOutput("stall_if",   32'(bus.stall_if),   32'(expStall));
        checkOutput("fwd_a", 32'(bus.fwd_a), 32'(modelFwd(mEx.rs1, mEx.sfp, mEx.u1)));
        checkOutput("fwd_b", 32'(bus.fwd_b), 32'(modelFwd(mEx.rs2, mEx.sfp, mEx.u2)));
        lastStall = bus.stall_if;
        lastFlush = bus.flush_ifid;
        @(posedge clk);
        mWb = mMem;
        if (busy) begin
            mMem = bubble();
            mExAge++;
        end else begin
            mMem = mEx;
            if (fl || lu || !id.v) begin
                mEx    = bubble();
                mExAge = 0;
            end else begin
                mEx    = id;
                mExAge = 1;
            end
        end
        @(negedge clk);
        checkRegs();
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        instr_t lw3, add, i1, i2, i3, multf, addf, lw6, dep, lf3, gpr3, addf3;
        instr_t cur;
        logic   br;
        logic   holdId;

        applyStimulus_idle: begin
            bus.id_valid = 1'b0; bus.id_ctrl = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
            bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0; bus.id_src_fp = 1'b0;
            bus.id_dest = '0; bus.id_dest_fp = 1'b0; bus.id_reg_we = 1'b0;
            bus.id_is_load = 1'b0; bus.id_fpu_multi = 1'b0; bus.ex_branch_taken = 1'b0;
        end
        modelReset();
        #12;
        checkResetState("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use: LW r3 ; ADD r5,r3,r4
        lw3 = mk(24'h0A0001, 0, 0, 0, 0, 0, 3, 0, 1, 1, 0);
        add = mk(24'h0A0002, 3, 1, 4, 1, 0, 5, 0, 1, 0, 0);
        applyStimulus(lw3, 0);
        applyStimulus(add, 0);
        checkOutput("tp1_stall",  32'(lastStall), 1);
        checkOutput("tp1_bubble", 32'(bus.ex_valid), 0);
        applyStimulus(add, 0);
        checkOutput("tp1_nostall", 32'(lastStall), 0);
        checkOutput("tp1_fwd_a",   32'(bus.fwd_a), 2);
        checkOutput("tp1_fwd_b",   32'(bus.fwd_b), 0);

        // Forwarding priority: ADD r2 ; SUB r2 ; OR r7,r2,r2, then r0 never forwards
        i1 = mk(24'h0B0001, 8, 1, 9, 1, 0, 2, 0, 1, 0, 0);
        i2 = mk(24'h0B0002, 10, 1, 11, 1, 0, 2, 0, 1, 0, 0);
        i3 = mk(24'h0B0003, 2, 1, 2, 1, 0, 7, 0, 1, 0, 0);
        applyStimulus(i1, 0);
        applyStimulus(i2, 0);
        applyStimulus(i3, 0);
        checkOutput("tp2_fwd_a", 32'(bus.fwd_a), 1);
        checkOutput("tp2_fwd_b", 32'(bus.fwd_b), 1);
        i1 = mk(24'h0B0004, 8, 1, 9, 1, 0, 0, 0, 1, 0, 0);
        i2 = mk(24'h0B0005, 0, 1, 0, 1, 0, 6, 0, 1, 0, 0);
        applyStimulus(i1, 0);
        applyStimulus(i2, 0);
        checkOutput("tp2_r0_a", 32'(bus.fwd_a), 0);
        checkOutput("tp2_r0_b", 32'(bus.fwd_b), 0);

        // Multi-cycle FPU: MULTF f1,f2,f3 ; ADDF f4,f1,f1
        multf = mk(24'h0C0001, 2, 1, 3, 1, 1, 1, 1, 1, 0, 1);
        addf  = mk(24'h0C0002, 1, 1, 1, 1, 1, 4, 1, 1, 0, 0);
        applyStimulus(multf, 0);
        checkOutput("tp3_busy", 32'(bus.fpu_busy), 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(addf, 0);
            checkOutput("tp3_stall", 32'(lastStall), 32'(i < 3));
            if (i < 3) checkOutput("tp3_memv", 32'(bus.mem_valid), 0);
        end
        checkOutput("tp3_memctrl", 32'(bus.mem_ctrl), 32'h0C0001);
        checkOutput("tp3_fwd_a",   32'(bus.fwd_a), 1);
        checkOutput("tp3_idle",    32'(bus.fpu_busy), 0);

        // Branch flush beats a pending load-use
        lw6 = mk(24'h0D0001, 0, 0, 0, 0, 0, 6, 0, 1, 1, 0);
        dep = mk(24'h0D0002, 6, 1, 1, 0, 0, 9, 0, 1, 0, 0);
        applyStimulus(lw6, 0);
        applyStimulus(dep, 1);
        checkOutput("tp4_flush",   32'(lastFlush), 1);
        checkOutput("tp4_stall",   32'(lastStall), 0);
        checkOutput("tp4_exv",     32'(bus.ex_valid), 0);
        checkOutput("tp4_memctrl", 32'(bus.mem_ctrl), 32'h0D0001);

        // FP/GPR namespaces: f3 producers never affect r3 consumers
        lf3   = mk(24'h0E0001, 0, 0, 0, 0, 0, 3, 1, 1, 1, 0);
        gpr3  = mk(24'h0E0002, 3, 1, 3, 1, 0, 8, 0, 1, 0, 0);
        addf3 = mk(24'h0E0003, 5, 1, 6, 1, 1, 3, 1, 1, 0, 0);
        applyStimulus(lf3, 0);
        applyStimulus(gpr3, 0);
        checkOutput("tp5_nostall", 32'(lastStall), 0);
        applyStimulus(addf3, 0);
        applyStimulus(gpr3, 0);
        checkOutput("tp5_fwd_a", 32'(bus.fwd_a), 0);
        checkOutput("tp5_fwd_b", 32'(bus.fwd_b), 0);

        // Reset in the middle of an FPU op
        applyStimulus(multf, 0);
        applyStimulus(bubble(), 0);
        checkOutput("tp6_busy_pre", 32'(bus.fpu_busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("tp6");
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(add, 0);
        checkOutput("tp6_nostall", 32'(lastStall), 0);
        checkOutput("tp6_exv",     32'(bus.ex_valid), 1);

        // Random phase: ID is held by the upstream while stalled
        holdId = 1'b0;
        cur    = bubble();
        for (int n = 0; n < 800; n++) begin
            if (!holdId) cur = randInstr();
            br = !modelBusy() && mEx.v && !mEx.ld && ($urandom_range(0, 7) == 0);
            applyStimulus(cur, br);
            holdId = expStall && cur.v;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_control.md
Name: pipe_control

Overview:
- Parametrised pipelined successor to the single-cycle DLX control decoder.
- Takes the decoded control word and register fields for the instruction in ID, and carries control bundles through the ID/EX, EX/MEM and MEM/WB registers with valid bits.
- Detects load-use and multi-cycle FPU hazards (stall), applies branch flushes, and generates EX-stage operand forwarding selects.
- Sits between the combinational decoder and the datapath pipeline registers.

Parameters:
- CTRL_W, 24: width of the opaque control bundle carried down the pipe.
- REG_AW, 5: register index width.
- FPU_LAT, 4: total EX-occupancy cycles of a multi-cycle FPU op; legal range 2..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_ctrl  in  CTRL_W  decoded control bundle.
- id_rs1, id_rs2  in  REG_AW  source indices.
- id_uses_rs1, id_uses_rs2  in  1  source actually read.
- id_src_fp  in  1  sources are FPRs (else GPRs).
- id_dest  in  REG_AW  destination index.
- id_dest_fp  in  1  destination is an FPR.
- id_reg_we  in  1  instruction writes a register.
- id_is_load  in  1  memory load.
- id_fpu_multi  in  1  multi-cycle FPU op.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- stall_if  out  1  hold PC and IF/ID.
- flush_ifid  out  1  squash IF/ID contents.
- fpu_busy  out  1  multi-cycle op occupying EX.
- ex_valid, mem_valid, wb_valid  out  1  stage valid.
- ex_ctrl, mem_ctrl, wb_ctrl  out  CTRL_W  stage control bundles.
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB.

Behaviour:
- **Reset:**
  - All valids are 0; all ctrl outputs, the FPU counter and the registered EX/MEM/WB dest/we/fp/load fields are 0.
  - stall_if, flush_ifid, fpu_busy and fwd_a/b evaluate to 0.
  - Reset asserted mid-stall or mid-FPU-op aborts it immediately.
- **Register match:**
  - A source matches a stage when that stage is valid, has we=1, dest==src index and dest_fp==id_src_fp.
  - GPR index 0 never matches.
  - FPR index 0 is matchable.
- **Load-use stall:** EX holds a valid load whose dest matches a used ID source -> stall_if=1 (combinational).
  - Next edge: EX gets a bubble (ex_valid=0), EX->MEM advances normally, ID is held.
  - Exactly 1 cycle.
- **Multi-cycle FPU:** when an id_fpu_multi op enters EX, the counter is loaded with FPU_LAT-1.
  - fpu_busy = (counter != 0).
  - While busy:
    - EX and its ctrl hold.
    - MEM receives bubbles.
    - stall_if=1.
    - The counter decrements each edge.
  - When the counter reaches 0, the op advances to MEM on the next edge.
  - Total EX residency is exactly FPU_LAT cycles.
- **Branch flush:** ex_branch_taken=1 -> flush_ifid=1.
  - Next edge: EX gets a bubble (the ID instruction is squashed).
  - The branch itself advances to MEM.
  - Flush takes priority over load-use stall for the ID instruction; stall_if is forced to 0 that cycle.
  - ex_branch_taken is ignored while fpu_busy (cannot co-occur legally).
- **Forwarding:** combinational from the registered EX sources (latched when the instruction enters EX).
  - 01 if MEM matches.
  - Else 10 if WB matches.
  - Else 00.
  - MEM has priority over WB.
  - Unused source -> 00.
  - A load in MEM never forwards (01 is suppressed); this cannot arise after a correct stall.
- **Stage advance:**
  - WB <= MEM and MEM <= EX every edge, except that MEM takes a bubble during fpu_busy.
  - WB retires in 1 cycle.
- **Bubble handling:**
  - id_valid=0 -> bubble into EX.
  - Bubble ctrl bundles are driven to 0.

Test Plan:
1. **Load-use stall:** LW r3 then ADD r5,r3,r4 back-to-back -> stall_if=1 for exactly 1 cycle; ex_valid=0 one cycle; then ADD in EX with fwd_a=10.
2. **Forwarding priority:** ADD r2 (older), SUB r2, OR r7,r2,r2 -> in EX, fwd_a=fwd_b=01 (MEM beats WB); GPR r0 as dest/source -> fwd stays 00.
3. **Multi-cycle FPU:** FPU_LAT=4 MULTF f1 -> fpu_busy high 3 cycles; stall_if high 3 cycles; mem_valid=0 for 3 cycles; MULTF reaches MEM on the 4th edge after entering EX; dependent f1 consumer later gets fwd 01.
4. **Branch flush:** ex_branch_taken=1 with a load-use condition pending in ID -> flush_ifid=1, stall_if=0, next ex_valid=0, branch visible in mem_valid.
5. **FP/GPR namespace:** FPR f3 dest vs GPR r3 source -> no stall, no forward.
6. **Reset mid-operation:** rst_n low during fpu_busy -> all outputs 0 asynchronously; after release a new instruction flows with no stall.
